// File: rtl/div_issue_ctrl_if.sv
// Bundle between the divide issue controller, the EX stage and the two divider IPs.
// The controller takes the master view; EX plus the IPs take the slave view.
interface div_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [DATA_W-1:0]     req_src1;
    logic [DATA_W-1:0]     req_src2;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_W-1:0]     res_data;

    logic [DATA_W-1:0]     dvd_tdata;
    logic [DATA_W-1:0]     dvs_tdata;

    logic                  s_dvd_tvalid;
    logic                  s_dvd_tready;
    logic                  s_dvs_tvalid;
    logic                  s_dvs_tready;
    logic                  s_dout_tvalid;
    logic [2*DATA_W-1:0]   s_dout_tdata;

    logic                  u_dvd_tvalid;
    logic                  u_dvd_tready;
    logic                  u_dvs_tvalid;
    logic                  u_dvs_tready;
    logic                  u_dout_tvalid;
    logic [2*DATA_W-1:0]   u_dout_tdata;

    modport master (
        input  req_valid, req_op, req_src1, req_src2, res_ready,
        input  s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
        input  u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata,
        output req_ready, res_valid, res_data, dvd_tdata, dvs_tdata,
        output s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid
    );

    modport slave (
        output req_valid, req_op, req_src1, req_src2, res_ready,
        output s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
        output u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata,
        input  req_ready, res_valid, res_data, dvd_tdata, dvs_tdata,
        input  s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequences one div/mod request through the signed or unsigned divider IP and
// returns quotient or remainder; a flush drains the IP result instead of returning it.
module div_issue_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    output logic              o_busy,
    div_issue_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_signed;
    logic                r_wantRem;
    logic [DATA_W-1:0]   r_src1;
    logic [DATA_W-1:0]   r_src2;
    logic [DATA_W-1:0]   r_resData;
    logic                r_dvdValid;
    logic                r_dvsValid;
    logic                r_flushPend;

    logic                w_opOneHot;
    logic                w_accept;
    logic                w_dvdReady;
    logic                w_dvsReady;
    logic                w_dvdDone;
    logic                w_dvsDone;
    logic                w_doutValid;
    logic [2*DATA_W-1:0] w_doutData;
    logic                w_capture;

    assign w_opOneHot  = (bus.req_op != 4'd0) && ((bus.req_op & (bus.req_op - 4'd1)) == 4'd0);
    assign w_accept    = (r_state == IDLE) && bus.req_valid && !i_flush && w_opOneHot;

    // Only the IP chosen at accept time is listened to; the other one is ignored.
    assign w_dvdReady  = r_signed ? bus.s_dvd_tready  : bus.u_dvd_tready;
    assign w_dvsReady  = r_signed ? bus.s_dvs_tready  : bus.u_dvs_tready;
    assign w_doutValid = r_signed ? bus.s_dout_tvalid : bus.u_dout_tvalid;
    assign w_doutData  = r_signed ? bus.s_dout_tdata  : bus.u_dout_tdata;

    assign w_dvdDone   = !r_dvdValid || w_dvdReady;
    assign w_dvsDone   = !r_dvsValid || w_dvsReady;
    assign w_capture   = (r_state == WAIT) && w_doutValid && !i_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   if (w_dvdDone && w_dvsDone) w_next = (r_flushPend || i_flush) ? DRAIN : WAIT;
            WAIT: begin
                if (w_doutValid) begin
                    w_next = i_flush ? IDLE : DONE;
                end else if (i_flush) begin
                    w_next = DRAIN;
                end
            end
            DONE:    if (bus.res_ready || i_flush) w_next = IDLE;
            DRAIN:   if (w_doutValid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A tvalid, once raised, stays up until its own handshake even across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_signed    <= 1'b0;
            r_wantRem   <= 1'b0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_dvdValid  <= 1'b0;
            r_dvsValid  <= 1'b0;
            r_flushPend <= 1'b0;
            r_resData   <= '0;
        end else begin
            if (w_accept) begin
                r_signed    <= bus.req_op[0] | bus.req_op[2];
                r_wantRem   <= bus.req_op[2] | bus.req_op[3];
                r_src1      <= bus.req_src1;
                r_src2      <= bus.req_src2;
                r_dvdValid  <= 1'b1;
                r_dvsValid  <= 1'b1;
                r_flushPend <= 1'b0;
            end else begin
                if (r_dvdValid && w_dvdReady) r_dvdValid <= 1'b0;
                if (r_dvsValid && w_dvsReady) r_dvsValid <= 1'b0;
                if ((r_state == ISSUE) && i_flush) r_flushPend <= 1'b1;
            end
            if (w_capture) begin
                r_resData <= r_wantRem ? w_doutData[DATA_W-1:0] : w_doutData[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_comb begin
        bus.req_ready    = (r_state == IDLE);
        o_busy           = (r_state != IDLE);
        bus.res_valid    = (r_state == DONE);
        bus.res_data     = r_resData;
        bus.dvd_tdata    = r_src1;
        bus.dvs_tdata    = r_src2;
        bus.s_dvd_tvalid = r_dvdValid &&  r_signed;
        bus.s_dvs_tvalid = r_dvsValid &&  r_signed;
        bus.u_dvd_tvalid = r_dvdValid && !r_signed;
        bus.u_dvs_tvalid = r_dvsValid && !r_signed;
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: two behavioural divider IPs, a transaction-level model of
// the controller, directed scenarios and a randomized soak checked every cycle.
module tb_div_issue_ctrl;
    localparam int W = 32;

    logic clk;
    logic reset;
    logic flush;
    logic busy;

    div_issue_ctrl_if #(.DATA_W(W)) bus ();

    div_issue_ctrl #(.DATA_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .o_busy  (busy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit mActive, mDvdOwed, mDvsOwed, mIssued, mCancelled, mHaveResult;
    logic [3:0]   mOp;
    logic [W-1:0] mA, mB, mResult;

    bit             ipGotDvd[2], ipGotDvs[2];
    logic [W-1:0]   ipA[2], ipB[2];
    logic [2*W-1:0] ipRes[2];
    int             ipCnt[2], dvsHigh[2];
    bit             sDvdV[2], sDvsV[2];
    logic [W-1:0]   sDvdData, sDvsData;

    bit           randMode, dReq, dFlushWait, dFlushIssue, dReset;
    int           holdReset, readyMode, fixedLat, holdCnt;
    logic [3:0]   dOp;
    logic [W-1:0] dA, dB;

    int           sDvdCnt, sDvsCnt, uDvdCnt, uDvsCnt, resCnt;
    logic [W-1:0] lastRes;

    function automatic bit isSigned(input logic [3:0] op);
        return op[0] | op[2];
    endfunction

    // Divide by zero returns {all ones, dividend}; otherwise truncating division.
    function automatic logic [2*W-1:0] ipDivide(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint na, nb, q, r;
        logic [63:0] qb, rb;
        if (b == '0) return {{W{1'b1}}, a};
        if (sgn) begin
            na = $signed(a);
            nb = $signed(b);
        end else begin
            na = {32'd0, a};
            nb = {32'd0, b};
        end
        q  = na / nb;
        r  = na % nb;
        qb = q;
        rb = r;
        return {qb[W-1:0], rb[W-1:0]};
    endfunction

    function automatic logic [W-1:0] expectRes(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] d;
        d = ipDivide(isSigned(op), a, b);
        return (op[2] | op[3]) ? d[W-1:0] : d[2*W-1:W];
    endfunction

    function automatic bit ipIdle(input int i);
        return (ipCnt[i] == 0) && !ipGotDvd[i] && !ipGotDvs[i];
    endfunction

    task automatic cmp1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic cmpW(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic cmpInt(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // IPs react to the handshakes that completed on the edge just past.
    task automatic envUpdate();
        logic dvdR, dvsR;
        for (int i = 0; i < 2; i++) begin
            dvdR = (i == 0) ? bus.s_dvd_tready : bus.u_dvd_tready;
            dvsR = (i == 0) ? bus.s_dvs_tready : bus.u_dvs_tready;
            if (reset) begin
                ipGotDvd[i] = 1'b0;
                ipGotDvs[i] = 1'b0;
                dvsHigh[i]  = 0;
            end else begin
                if (sDvdV[i] && dvdR) begin
                    ipGotDvd[i] = 1'b1;
                    ipA[i]      = sDvdData;
                end
                if (sDvsV[i] && dvsR) begin
                    ipGotDvs[i] = 1'b1;
                    ipB[i]      = sDvsData;
                    dvsHigh[i]  = 0;
                end else if (sDvsV[i]) begin
                    dvsHigh[i]++;
                end
                if (ipGotDvd[i] && ipGotDvs[i]) begin
                    ipGotDvd[i] = 1'b0;
                    ipGotDvs[i] = 1'b0;
                    ipCnt[i]    = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 5));
                    ipRes[i]    = ipDivide(i == 0, ipA[i], ipB[i]);
                end
            end
        end
    endtask

    task automatic modelStep();
        bit sg;
        logic dvdR, dvsR, doutV;
        sg    = isSigned(mOp);
        dvdR  = sg ? bus.s_dvd_tready  : bus.u_dvd_tready;
        dvsR  = sg ? bus.s_dvs_tready  : bus.u_dvs_tready;
        doutV = sg ? bus.s_dout_tvalid : bus.u_dout_tvalid;
        if (reset) begin
            mActive = 0; mDvdOwed = 0; mDvsOwed = 0; mIssued = 0; mCancelled = 0; mHaveResult = 0;
            mOp = '0; mResult = '0;
        end else if (!mActive) begin
            if (bus.req_valid && !flush && $onehot(bus.req_op)) begin
                mActive = 1; mDvdOwed = 1; mDvsOwed = 1; mIssued = 0; mCancelled = 0; mHaveResult = 0;
                mOp = bus.req_op; mA = bus.req_src1; mB = bus.req_src2;
                dReq = 0;
            end
        end else if (mHaveResult) begin
            if (bus.res_ready || flush) begin
                mActive = 0;
                mHaveResult = 0;
            end
        end else if (!mIssued) begin
            if (flush) mCancelled = 1;
            if (mDvdOwed && dvdR) mDvdOwed = 0;
            if (mDvsOwed && dvsR) mDvsOwed = 0;
            if (!mDvdOwed && !mDvsOwed) mIssued = 1;
        end else begin
            if (doutV) begin
                if (!mCancelled && !flush) begin
                    mHaveResult = 1;
                    mResult = expectRes(mOp, mA, mB);
                end else begin
                    mActive = 0;
                end
            end else if (flush) begin
                mCancelled = 1;
            end
        end
    endtask

    task automatic checkOutput();
        bit sg, issuing;
        sg      = isSigned(mOp);
        issuing = mActive && !mIssued;
        cmp1("busy", busy, mActive);
        cmp1("req_ready", bus.req_ready, !mActive);
        cmp1("res_valid", bus.res_valid, mHaveResult);
        cmpW("res_data", bus.res_data, mResult);
        cmp1("s_dvd_tvalid", bus.s_dvd_tvalid, issuing && mDvdOwed && sg);
        cmp1("s_dvs_tvalid", bus.s_dvs_tvalid, issuing && mDvsOwed && sg);
        cmp1("u_dvd_tvalid", bus.u_dvd_tvalid, issuing && mDvdOwed && !sg);
        cmp1("u_dvs_tvalid", bus.u_dvs_tvalid, issuing && mDvsOwed && !sg);
        if (issuing) begin
            cmpW("dvd_tdata", bus.dvd_tdata, mA);
            cmpW("dvs_tdata", bus.dvs_tdata, mB);
        end
        sDvdV[0] = bus.s_dvd_tvalid; sDvsV[0] = bus.s_dvs_tvalid;
        sDvdV[1] = bus.u_dvd_tvalid; sDvsV[1] = bus.u_dvs_tvalid;
        sDvdData = bus.dvd_tdata;    sDvsData = bus.dvs_tdata;
        if (bus.s_dvd_tvalid) sDvdCnt++;
        if (bus.s_dvs_tvalid) sDvsCnt++;
        if (bus.u_dvd_tvalid) uDvdCnt++;
        if (bus.u_dvs_tvalid) uDvsCnt++;
        if (bus.res_valid) begin
            resCnt++;
            lastRes = bus.res_data;
        end
    endtask

    task automatic applyStimulus();
        bit idleAll, issuing, awaiting, holdOff;
        bit dvdR[2], dvsR[2], dV[2], wasIdle;
        logic [2*W-1:0] dD[2];
        idleAll  = ipIdle(0) && ipIdle(1);
        issuing  = mActive && !mIssued;
        awaiting = mActive && mIssued && !mHaveResult && !mCancelled;

        if (holdReset > 0) begin
            reset = 1'b1;
            holdReset--;
        end else if (randMode) begin
            reset = ($urandom_range(0, 399) == 0);
        end else if (dReset && awaiting) begin
            reset = 1'b1;
            dReset = 0;
        end else begin
            reset = 1'b0;
        end

        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_src1  = $urandom();
        bus.req_src2  = $urandom();
        flush         = 1'b0;
        bus.res_ready = 1'b1;
        if (randMode) begin
            if (mActive || idleAll) bus.req_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 8) bus.req_op = 4'b0001 << $urandom_range(0, 3);
            else bus.req_op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: bus.req_src1 = 32'h8000_0000;
                1: bus.req_src1 = $urandom_range(0, 100);
                default: ;
            endcase
            case ($urandom_range(0, 9))
                0: bus.req_src2 = '0;
                1: bus.req_src2 = '1;
                2, 3: bus.req_src2 = $urandom_range(1, 20);
                default: ;
            endcase
            flush         = ($urandom_range(0, 14) == 0);
            bus.res_ready = ($urandom_range(0, 1) == 1);
        end else begin
            if (dReq && !mActive && idleAll) begin
                bus.req_valid = 1'b1;
                bus.req_op    = dOp;
                bus.req_src1  = dA;
                bus.req_src2  = dB;
            end
            if (dFlushWait && awaiting) begin
                flush = 1'b1;
                dFlushWait = 0;
            end
            if (dFlushIssue && issuing) begin
                flush = 1'b1;
                dFlushIssue = 0;
            end
        end

        holdOff = 0;
        if (!randMode && readyMode == 3 && issuing && holdCnt > 0) begin
            holdOff = 1;
            holdCnt--;
        end
        for (int i = 0; i < 2; i++) begin
            wasIdle = ipIdle(i);
            dvdR[i] = !ipGotDvd[i] && ipCnt[i] == 0;
            dvsR[i] = !ipGotDvs[i] && ipCnt[i] == 0;
            if (randMode) begin
                dvdR[i] = dvdR[i] && ($urandom_range(0, 1) == 1);
                dvsR[i] = dvsR[i] && ($urandom_range(0, 1) == 1);
            end else if (readyMode == 2) begin
                dvsR[i] = dvsR[i] && sDvsV[i] && dvsHigh[i] >= 3;
            end else if (readyMode == 3 && holdOff) begin
                dvdR[i] = 1'b0;
                dvsR[i] = 1'b0;
            end
            dV[i] = 1'b0;
            dD[i] = {$urandom(), $urandom()};
            if (ipCnt[i] > 0) begin
                ipCnt[i]--;
                if (ipCnt[i] == 0) begin
                    dV[i] = 1'b1;
                    dD[i] = ipRes[i];
                end
            end else if (randMode && wasIdle && $urandom_range(0, 29) == 0) begin
                dV[i] = 1'b1;
            end
        end
        bus.s_dvd_tready  = dvdR[0]; bus.s_dvs_tready = dvsR[0];
        bus.u_dvd_tready  = dvdR[1]; bus.u_dvs_tready = dvsR[1];
        bus.s_dout_tvalid = dV[0];   bus.s_dout_tdata = dD[0];
        bus.u_dout_tvalid = dV[1];   bus.u_dout_tdata = dD[1];
    endtask

    task automatic cycle();
        @(negedge clk);
        envUpdate();
        modelStep();
        checkOutput();
        applyStimulus();
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((mActive || dReq || !(ipIdle(0) && ipIdle(1))) && n < maxCycles);
        if (mActive || dReq || !(ipIdle(0) && ipIdle(1))) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: transaction open after %0d cycles, required idle", n);
        end
    endtask

    task automatic startTxn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        sDvdCnt = 0; sDvsCnt = 0; uDvdCnt = 0; uDvsCnt = 0; resCnt = 0; lastRes = '0;
        dOp = op; dA = a; dB = b; dReq = 1;
    endtask

    initial begin
        randMode = 0; dReq = 0; dFlushWait = 0; dFlushIssue = 0; dReset = 0;
        holdReset = 3; readyMode = 1; fixedLat = 3; holdCnt = 0;
        for (int i = 0; i < 2; i++) begin
            ipGotDvd[i] = 0; ipGotDvs[i] = 0; ipCnt[i] = 0; dvsHigh[i] = 0;
            sDvdV[i] = 0; sDvsV[i] = 0;
        end
        mOp = '0; mA = '0; mB = '0; mResult = '0;
        applyStimulus();

        cmpW("model div 100/7", expectRes(4'b0001, 32'd100, 32'd7), 32'd14);
        cmpW("model mod -7/2", expectRes(4'b0100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        cmpW("model divu", expectRes(4'b0010, 32'hFFFF_FFFF, 32'd2), 32'h7FFF_FFFF);
        cmpW("model modu 10/3", expectRes(4'b1000, 32'd10, 32'd3), 32'd1);

        repeat (4) cycle();

        $display("[TB] div 100/7, IPs always ready");
        startTxn(4'b0001, 32'd100, 32'd7);
        runUntilIdle(50);
        cmpW("div 100/7 result", lastRes, 32'd14);
        cmpInt("div result beats", resCnt, 1);
        cmpInt("s_dvd_tvalid cycles", sDvdCnt, 1);
        cmpInt("s_dvs_tvalid cycles", sDvsCnt, 1);

        $display("[TB] mod -7/2 signed");
        startTxn(4'b0100, 32'hFFFF_FFF9, 32'd2);
        runUntilIdle(50);
        cmpW("mod -7/2 result", lastRes, 32'hFFFF_FFFF);
        cmpInt("u tvalid cycles on signed op", uDvdCnt + uDvsCnt, 0);

        $display("[TB] divu with divisor tready 3 cycles late");
        readyMode = 2;
        startTxn(4'b0010, 32'hFFFF_FFFF, 32'd2);
        runUntilIdle(50);
        cmpW("divu result", lastRes, 32'h7FFF_FFFF);
        cmpInt("u_dvd_tvalid cycles", uDvdCnt, 1);
        cmpInt("u_dvs_tvalid cycles", uDvsCnt, 4);
        cmpInt("s tvalid cycles on unsigned op", sDvdCnt + sDvsCnt, 0);

        $display("[TB] modu 10/3 flushed in WAIT, then div 9/3");
        readyMode = 1; fixedLat = 5; dFlushWait = 1;
        startTxn(4'b1000, 32'd10, 32'd3);
        runUntilIdle(50);
        cmpInt("flushed modu result beats", resCnt, 0);
        fixedLat = 3;
        startTxn(4'b0001, 32'd9, 32'd3);
        runUntilIdle(50);
        cmpW("div 9/3 result", lastRes, 32'd3);
        cmpInt("div 9/3 result beats", resCnt, 1);

        $display("[TB] flush in ISSUE with tready low");
        readyMode = 3; holdCnt = 4; dFlushIssue = 1;
        startTxn(4'b0001, 32'd20, 32'd4);
        runUntilIdle(50);
        cmpInt("held s_dvd_tvalid cycles", sDvdCnt, 5);
        cmpInt("held s_dvs_tvalid cycles", sDvsCnt, 5);
        cmpInt("flushed issue result beats", resCnt, 0);

        $display("[TB] reset asserted in WAIT");
        readyMode = 1; fixedLat = 6; dReset = 1;
        startTxn(4'b0010, 32'd50, 32'd5);
        runUntilIdle(60);
        cmpInt("reset-in-wait result beats", resCnt, 0);
        cmp1("busy after reset", busy, 1'b0);
        cmp1("req_ready after reset", bus.req_ready, 1'b1);
        cmpW("res_data after reset", bus.res_data, 32'd0);

        $display("[TB] randomized soak");
        randMode = 1; fixedLat = 0; readyMode = 0;
        repeat (3000) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
